// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/xor and an iterative one-bit-per-cycle shifter.
// Define ALU_EXEC_FASTSHIFT_EN to use a single-cycle barrel shifter instead (busy tied low).
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluCtrl,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_XOR = 4'b0011;
    localparam logic [3:0] CTRL_SRL = 4'b0100;
    localparam logic [3:0] CTRL_SLL = 4'b0101;

    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] imm_result;
    logic             imm_illegal;
    logic             accept_imm;
    logic             finish_shift;
    logic [WIDTH-1:0] shift_final;
    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             illegal_d, illegal_q;
    logic             done_d, done_q;

    assign amt = opB[SHW-1:0];

    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    always_comb begin
        imm_result  = '0;
        imm_illegal = 1'b0;
        case (aluCtrl)
            CTRL_ADD: imm_result = opA + opB;
            CTRL_SUB: imm_result = opA - opB;
            CTRL_XOR: imm_result = opA ^ opB;
`ifdef ALU_EXEC_FASTSHIFT_EN
            CTRL_SRL: imm_result = opA >> amt;
            CTRL_SLL: imm_result = opA << amt;
`else
            // Only reached for a zero shift amount; nonzero shifts go iterative.
            CTRL_SRL, CTRL_SLL: imm_result = opA;
`endif
            default:  imm_illegal = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_FASTSHIFT_EN
    assign busy         = 1'b0;
    assign accept_imm   = start;
    assign finish_shift = 1'b0;
    assign shift_final  = '0;
`else
    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_left_q, dir_left_d;
    logic             is_shift;
    logic             launch;

    assign is_shift     = (aluCtrl == CTRL_SRL) || (aluCtrl == CTRL_SLL);
    assign launch       = (state_q == S_IDLE) && start && is_shift && (amt != '0);
    assign accept_imm   = (state_q == S_IDLE) && start && !launch;
    assign finish_shift = (state_q == S_SHIFT) && (cnt_q == SHW'(1));
    assign shift_final  = dir_left_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (launch)            state_d = S_SHIFT;
        else if (finish_shift) state_d = S_IDLE;
    end

    always_comb begin
        busy = (state_q == S_SHIFT);
    end

    always_comb begin
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        dir_left_d = dir_left_q;
        if (launch) begin
            cnt_d      = amt;
            shreg_d    = opA;
            dir_left_d = (aluCtrl == CTRL_SLL);
        end else if (state_q == S_SHIFT) begin
            cnt_d   = cnt_q - SHW'(1);
            shreg_d = shift_final;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            shreg_q    <= '0;
            dir_left_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            dir_left_q <= dir_left_d;
        end
    end
`endif

    // Architectural outputs move only on a completion edge.
    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        if (finish_shift) begin
            result_d  = shift_final;
            zero_d    = (shift_final == '0);
            illegal_d = 1'b0;
            done_d    = 1'b1;
        end else if (accept_imm) begin
            result_d  = imm_result;
            zero_d    = (imm_result == '0);
            illegal_d = imm_illegal;
            done_d    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;
    assign done    = done_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops checked
// against an arithmetic reference model of results and shift latency.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   aluCtrl;
    logic [W-1:0] opA, opB;
    logic         busy, done, zero, illegal;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_result  = '0;
    logic         exp_illegal = 1'b0;

    alu_exec_unit #(.WIDTH(W), .SHW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .aluCtrl (aluCtrl),
        .opA     (opA),
        .opB     (opB),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero),
        .illegal (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: result from plain arithmetic; latency equals the shift amount for shifts.
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b % W);
        ill = 1'b0;
        lat = 0;
        case (c)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0011: r = a ^ b;
            4'b0100: begin r = a >> sh; lat = sh; end
            4'b0101: begin r = a << sh; lat = sh; end
            default: begin r = '0; ill = 1'b1; end
        endcase
`ifdef ALU_EXEC_FASTSHIFT_EN
        lat = 0;
`endif
    endfunction

    // Called at a falling edge; returns at the falling edge inside the done cycle.
    task automatic issue(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit noise);
        logic [W-1:0] r;
        logic         ill;
        int           lat;
        model(c, a, b, r, ill, lat);
        aluCtrl = c;
        opA     = a;
        opB     = b;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_done_low"}, done, 1'b0);
            check({tag, "_hold"}, result, exp_result);
            if (noise) begin
                start   = 1'($urandom);
                aluCtrl = 4'($urandom);
                opA     = $urandom;
                opB     = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        exp_result  = r;
        exp_illegal = ill;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_result"}, result, exp_result);
        check({tag, "_zero"}, zero, (exp_result == '0));
        check({tag, "_illegal"}, illegal, exp_illegal);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_done", done, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_result", result, exp_result);
        end
    endtask

    initial begin
        logic [3:0]   c;
        logic [W-1:0] a, b;
        start   = 1'b0;
        aluCtrl = '0;
        opA     = '0;
        opB     = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_result", result, '0);
        check("rst_zero", zero, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        rst_n = 1'b1;
        idle(1);

        issue("add", 4'b0010, 32'd5, 32'd7, 1'b0);
        issue("sub_zero", 4'b0110, 32'd9, 32'd9, 1'b0);
        issue("sub_wrap", 4'b0110, 32'd0, 32'd1, 1'b0);
        check("sub_wrap_value", result, 32'hFFFF_FFFF);
        idle(2);
        issue("sll31", 4'b0101, 32'd1, 32'd31, 1'b1);
        check("sll31_value", result, 32'h8000_0000);
        issue("srl4", 4'b0100, 32'h8000_0000, 32'd4, 1'b0);
        check("srl4_value", result, 32'h0800_0000);
        issue("xor_b2b", 4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0);
        check("xor_b2b_value", result, 32'h0000_FF00);
        issue("srl_by0", 4'b0100, 32'h0000_1234, 32'h0000_0020, 1'b0);

        // Reset during the tenth busy cycle of an sll by 20.
        aluCtrl = 4'b0101;
        opA     = 32'd1;
        opB     = 32'd20;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
`ifndef ALU_EXEC_FASTSHIFT_EN
        check("midrst_busy_before", busy, 1'b1);
`endif
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_result", result, '0);
        check("midrst_zero", zero, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_illegal", illegal, 1'b0);
        @(negedge clk);
        rst_n       = 1'b1;
        exp_result  = '0;
        exp_illegal = 1'b0;
        idle(12);
        issue("add_after_rst", 4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0);
        check("add_after_rst_value", result, 32'h8000_0000);

        issue("illegal", 4'b0111, 32'd3, 32'd4, 1'b0);
        check("illegal_flag", illegal, 1'b1);
        issue("add_clears", 4'b0010, 32'd1, 32'd1, 1'b0);
        check("add_clears_flag", illegal, 1'b0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0:       c = 4'b0010;
                1:       c = 4'b0110;
                2:       c = 4'b0011;
                3:       c = 4'b0100;
                4:       c = 4'b0101;
                default: c = 4'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ((c == 4'b0100 || c == 4'b0101) && $urandom_range(0, 1) == 1)
                b = 32'($urandom_range(0, 3));
            issue("rand", c, a, b, 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
